// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register slice.
//   ex_mem_ctrl_t : memory/writeback control bits carried from EX to MEM
//   XLEN_DEF / REG_AW_DEF : default datapath and register-address widths
//   REG_ZERO      : architectural zero register index (writes are discarded)
//   ctrl_gate()   : forces control to zero on a bubble
package pipe_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic MemWrite;
    logic MemRead;
  } ex_mem_ctrl_t;

  localparam int unsigned CtrlW = $bits(ex_mem_ctrl_t);

  function automatic ex_mem_ctrl_t ctrl_gate(input ex_mem_ctrl_t ctrl, input logic valid);
    return valid ? ctrl : '0;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with valid/ready handshake and synchronous flush.
// The upstream ready is a flop, so there is no combinational path from
// out_ready_i to in_ready_o. The output slot always holds the oldest entry;
// the skid slot only fills when an entry arrives while the output is stalled.
// Ports:
//   clk_i, reset_i (sync, active-high), flush_i (drops everything held and incoming)
//   in_valid_i / in_ready_o / in_data_i    : upstream side
//   out_valid_o / out_ready_i / out_data_o : downstream side (registered)
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      // Data stays stale on purpose; only the valid bits are cleared.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid is only occupied behind a valid output; drain it first.
      if (out_ready_i) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_valid_i && in_ready_q) begin
      if (!out_valid_q || out_ready_i) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready flow control, synchronous flush
// and suppression of writes to register x0. One-cycle latency, one transfer
// per cycle sustained.
// Configuration macro: EX_MEM_SKID_EN
//   defined   : two-entry skid buffer, registered in_ready
//   undefined : single register, in_ready = !out_valid || out_ready
// Ports:
//   clk, reset (sync, active-high), flush (squash held and incoming entries)
//   in_valid/in_ready, RegWrite/MemtoReg/MemWrite/MemRead, AluResult, Datain, Rd_in
//   out_valid/out_ready, RegWrite_Out/MemtoReg_Out/MemWrite_Out/MemRead_out,
//   AluOut, DataOut, Rd_out
// Control outputs read 0 whenever out_valid is low; data outputs keep their
// last captured value.
module ex_mem_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [XLEN-1:0]   AluResult,
  input  logic [XLEN-1:0]   Datain,
  input  logic [REG_AW-1:0] Rd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWrite_Out,
  output logic              MemtoReg_Out,
  output logic              MemWrite_Out,
  output logic              MemRead_out,
  output logic [XLEN-1:0]   AluOut,
  output logic [XLEN-1:0]   DataOut,
  output logic [REG_AW-1:0] Rd_out
);

  localparam int unsigned PayW = CtrlW + 2 * XLEN + REG_AW;

  ex_mem_ctrl_t     in_ctrl, held_ctrl, out_ctrl;
  logic [PayW-1:0]  in_pay, held_pay;
  logic             held_valid;
  logic [XLEN-1:0]  held_alu, held_data;
  logic [REG_AW-1:0] held_rd;

  always_comb begin
    in_ctrl          = '0;
    in_ctrl.RegWrite = RegWrite && (Rd_in != REG_AW'(REG_ZERO));
    in_ctrl.MemtoReg = MemtoReg;
    in_ctrl.MemWrite = MemWrite;
    in_ctrl.MemRead  = MemRead;
  end

  assign in_pay = {in_ctrl, AluResult, Datain, Rd_in};

`ifdef EX_MEM_SKID_EN
  pipe_skid_buf #(
    .Width(PayW)
  ) u_skid (
    .clk_i      (clk),
    .reset_i    (reset),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_pay),
    .out_valid_o(held_valid),
    .out_ready_i(out_ready),
    .out_data_o (held_pay)
  );
`else
  logic            valid_q, valid_d;
  logic [PayW-1:0] pay_q, pay_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      pay_d   = in_pay;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign held_valid = valid_q;
  assign held_pay   = pay_q;
`endif

  assign {held_ctrl, held_alu, held_data, held_rd} = held_pay;
  assign out_ctrl = ctrl_gate(held_ctrl, held_valid);

  assign out_valid    = held_valid;
  assign RegWrite_Out = out_ctrl.RegWrite;
  assign MemtoReg_Out = out_ctrl.MemtoReg;
  assign MemWrite_Out = out_ctrl.MemWrite;
  assign MemRead_out  = out_ctrl.MemRead;
  assign AluOut       = held_alu;
  assign DataOut      = held_data;
  assign Rd_out       = held_rd;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed steps followed by a
// randomised stream, all checked against a queue-based reference model.
module tb_ex_mem_pipe_reg;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        mr;
    logic [63:0] alu;
    logic [63:0] din;
    logic [4:0]  rd;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic        RegWrite, MemtoReg, MemWrite, MemRead;
  logic        RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_out;
  logic [63:0] AluResult, Datain, AluOut, DataOut;
  logic [4:0]  Rd_in, Rd_out;

  int vectors     = 0;
  int miscompares = 0;

  ent_t q[$];      // entries held by the register, oldest first
  ent_t src_q[$];  // upstream entries waiting to be accepted
  ent_t disp;      // what the data outputs currently show
  logic from_src;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(
    .XLEN  (64),
    .REG_AW(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .AluResult   (AluResult),
    .Datain      (Datain),
    .Rd_in       (Rd_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .RegWrite_Out(RegWrite_Out),
    .MemtoReg_Out(MemtoReg_Out),
    .MemWrite_Out(MemWrite_Out),
    .MemRead_out (MemRead_out),
    .AluOut      (AluOut),
    .DataOut     (DataOut),
    .Rd_out      (Rd_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.rw  = 1'($urandom_range(1));
    e.m2r = 1'($urandom_range(1));
    e.mw  = 1'($urandom_range(1));
    e.mr  = 1'($urandom_range(1));
    e.alu = {$urandom, $urandom};
    e.din = {$urandom, $urandom};
    e.rd  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
    return e;
  endfunction

  function automatic ent_t mk_ent(input logic rw, input logic mw, input logic [63:0] alu,
                                  input logic [63:0] din, input logic [4:0] rd);
    ent_t e;
    e.rw = rw; e.m2r = 1'b0; e.mw = mw; e.mr = 1'b0;
    e.alu = alu; e.din = din; e.rd = rd;
    return e;
  endfunction

  task automatic drive(input ent_t e);
    RegWrite = e.rw; MemtoReg = e.m2r; MemWrite = e.mw; MemRead = e.mr;
    AluResult = e.alu; Datain = e.din; Rd_in = e.rd;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic tick();
    ent_t exp_e, cap;
    logic exp_ov, exp_ir, acc;
    #1;
    exp_ov = (q.size() > 0);
`ifdef EX_MEM_SKID_EN
    exp_ir = (q.size() < 2);
`else
    exp_ir = (q.size() == 0) || out_ready;
`endif
    exp_e = exp_ov ? q[0] : disp;
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("RegWrite_Out", 64'(RegWrite_Out), 64'(exp_ov && exp_e.rw));
    chk("MemtoReg_Out", 64'(MemtoReg_Out), 64'(exp_ov && exp_e.m2r));
    chk("MemWrite_Out", 64'(MemWrite_Out), 64'(exp_ov && exp_e.mw));
    chk("MemRead_out", 64'(MemRead_out), 64'(exp_ov && exp_e.mr));
    chk("AluOut", AluOut, exp_e.alu);
    chk("DataOut", DataOut, exp_e.din);
    chk("Rd_out", 64'(Rd_out), 64'(exp_e.rd));
    acc = in_valid && exp_ir;
    cap = mk_ent(RegWrite && (Rd_in != 5'd0), MemWrite, AluResult, Datain, Rd_in);
    cap.m2r = MemtoReg;
    cap.mr  = MemRead;
    @(posedge clk);
    if (reset) begin
      q.delete();
      disp = mk_ent(1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
    end else if (flush) begin
      q.delete();
    end else begin
      if (exp_ov && out_ready) void'(q.pop_front());
      if (acc) q.push_back(cap);
    end
    if (q.size() > 0) disp = q[0];
    if (acc && from_src && src_q.size() > 0) void'(src_q.pop_front());
    @(negedge clk);
  endtask

  // Feed src_q for n cycles. rdy_mode: 0 stalled, 1 ready, 2 random.
  task automatic stream(input int n, input int rdy_mode, input int flush_pct, input int rst_pct);
    for (int i = 0; i < n; i++) begin
      out_ready = (rdy_mode == 2) ? 1'($urandom_range(1)) : 1'(rdy_mode);
      flush     = ($urandom_range(99) < flush_pct);
      reset     = ($urandom_range(99) < rst_pct);
      from_src  = (src_q.size() > 0) && (rdy_mode != 2 || $urandom_range(3) != 0);
      in_valid  = from_src;
      if (from_src) drive(src_q[0]);
      tick();
    end
    from_src = 1'b0; in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  initial begin
    ent_t a;
    disp = mk_ent(1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
    from_src = 1'b0;
    // Reset held with a write request presented.
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    drive(mk_ent(1'b1, 1'b1, 64'hAAAA, 64'hBBBB, 5'd7));
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0; in_valid = 1'b0;
    tick();  // first cycle after release: in_ready must be 1

    // Pass-through.
    drive(mk_ent(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0010, 64'h1234, 5'd5));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("pt_valid", 64'(out_valid), 64'd1);
    chk("pt_alu", AluOut, 64'hDEAD_BEEF_0000_0010);
    chk("pt_data", DataOut, 64'h1234);
    chk("pt_rd", 64'(Rd_out), 64'd5);
    chk("pt_rw", 64'(RegWrite_Out), 64'd1);
    tick();

    // x0 suppression.
    drive(mk_ent(1'b1, 1'b0, 64'h40, 64'h41, 5'd0));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("x0_valid", 64'(out_valid), 64'd1);
    chk("x0_rd", 64'(Rd_out), 64'd0);
    chk("x0_rw", 64'(RegWrite_Out), 64'd0);
    tick();

    // Stall with A,B,C streaming, then release.
    a = mk_ent(1'b1, 1'b1, 64'hA0, 64'hA1, 5'd1);
    src_q.push_back(a);
    src_q.push_back(mk_ent(1'b1, 1'b0, 64'hB0, 64'hB1, 5'd2));
    src_q.push_back(mk_ent(1'b0, 1'b1, 64'hC0, 64'hC1, 5'd3));
    stream(3, 0, 0, 0);
    out_ready = 1'b0;
    #1;
    chk("stall_alu", AluOut, 64'hA0);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    stream(6, 1, 0, 0);
    chk("stall_src_empty", 64'(src_q.size()), 64'd0);

    // Flush with held entry and a same-cycle input.
    src_q.push_back(mk_ent(1'b1, 1'b0, 64'hD0, 64'hD1, 5'd4));
    stream(1, 0, 0, 0);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    drive(mk_ent(1'b1, 1'b1, 64'hE0, 64'hE1, 5'd6));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_rw", 64'(RegWrite_Out), 64'd0);
    chk("flush_mw", 64'(MemWrite_Out), 64'd0);
    src_q.push_back(mk_ent(1'b1, 1'b0, 64'hF0, 64'hF1, 5'd8));
    stream(3, 1, 0, 0);

    // Reset mid-stall, then flush together with reset.
    src_q.push_back(rand_ent());
    src_q.push_back(rand_ent());
    src_q.push_back(rand_ent());
    stream(2, 0, 0, 0);
    reset = 1'b1; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_alu", AluOut, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    stream(2, 0, 0, 0);
    reset = 1'b1; flush = 1'b1; out_ready = 1'b0;
    tick();
    reset = 1'b0; flush = 1'b0;
    #1;
    chk("rstfl_valid", 64'(out_valid), 64'd0);
    chk("rstfl_data", DataOut, 64'd0);
    src_q.delete();

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) src_q.push_back(rand_ent());
    stream(1500, 2, 4, 1);
    stream(20, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
